// File: rtl/mont_exp_ctrl.sv
// Modular exponentiation sequencer: left-to-right square-and-multiply over a
// Montgomery-domain base, then one multiply by 1 to return to normal domain.
// Latency: 3 cycles start->first mul_start; then one multiply per step, plus FIN.
// Backpressure: none; each multiply waits for mul_done, start ignored while busy.
module mont_exp_ctrl #(
  parameter int W     = 1024,
  parameter int EXP_W = 1024,
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_r,
  input  logic [EXP_W-1:0] in_e,
  input  logic [LEN_W-1:0] e_len,
  input  logic [W-1:0]     in_m,
  output logic             mul_start,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  output logic [W-1:0]     mul_m,
  input  logic [W:0]       mul_result,
  input  logic             mul_done,
  output logic [W-1:0]     result,
  output logic             busy,
  output logic             done
);

  // Exponent bit index only needs enough bits to address e_reg.
  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_SQR,
    S_SQR_W,
    S_MUL,
    S_MUL_W,
    S_CONV,
    S_CONV_W,
    S_FIN
  } state_t;

  state_t           state;
  logic [W-1:0]     acc;
  logic [W-1:0]     x_reg;
  logic [EXP_W-1:0] e_reg;
  logic [LEN_W-1:0] k;
  logic [IDX_W-1:0] k_idx;
  logic             e_bit;
  logic             unused_msb;

  // k never exceeds EXP_W-1 when used as a bit index, so the low bits suffice.
  assign k_idx = k[IDX_W-1:0];
  assign e_bit = e_reg[k_idx];

  // Multiplier result is already reduced below M; its top bit carries nothing.
  assign unused_msb = mul_result[W];

  // Sequencer: operand muxing, exponent bit walk and accumulator update.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_m     <= '0;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      acc       <= '0;
      x_reg     <= '0;
      e_reg     <= '0;
      k         <= '0;
    end else begin
      mul_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x_reg <= in_x;
            e_reg <= in_e;
            mul_m <= in_m;
            acc   <= in_r;
            k     <= e_len;
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (k == '0) begin
            state <= S_CONV;
          end else begin
            k     <= k - 1'b1;
            state <= S_SQR;
          end
        end
        S_SQR: begin
          mul_a     <= acc;
          mul_b     <= acc;
          mul_start <= 1'b1;
          state     <= S_SQR_W;
        end
        S_SQR_W: begin
          if (mul_done) begin
            acc <= mul_result[W-1:0];
            if (e_bit) begin
              state <= S_MUL;
            end else if (k == '0) begin
              state <= S_CONV;
            end else begin
              k     <= k - 1'b1;
              state <= S_SQR;
            end
          end
        end
        S_MUL: begin
          mul_a     <= acc;
          mul_b     <= x_reg;
          mul_start <= 1'b1;
          state     <= S_MUL_W;
        end
        S_MUL_W: begin
          if (mul_done) begin
            acc <= mul_result[W-1:0];
            if (k == '0) begin
              state <= S_CONV;
            end else begin
              k     <= k - 1'b1;
              state <= S_SQR;
            end
          end
        end
        S_CONV: begin
          // Multiplying by plain 1 strips the R factor from the accumulator.
          mul_a     <= acc;
          mul_b     <= ONE;
          mul_start <= 1'b1;
          state     <= S_CONV_W;
        end
        S_CONV_W: begin
          if (mul_done) begin
            result <= mul_result[W-1:0];
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_FIN;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Self-checking bench for mont_exp_ctrl with W=8, M=239, R=256.
// A behavioural Montgomery multiplier answers each mul_start after mul_lat cycles.
// Expected operands/results are queued at launch and popped by independent monitors.
module tb_mont_exp_ctrl;
  localparam int W     = 8;
  localparam int EXP_W = 8;
  localparam int LEN_W = 4;
  localparam int M     = 239;
  localparam int RM    = 17;  // 256 mod 239

  typedef struct {
    int a;
    int b;
  } op_t;

  logic             clk = 1'b0;
  logic             resetn;
  logic             start;
  logic [W-1:0]     in_x;
  logic [W-1:0]     in_r;
  logic [EXP_W-1:0] in_e;
  logic [LEN_W-1:0] e_len;
  logic [W-1:0]     in_m;
  logic             mul_start;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [W-1:0]     mul_m;
  logic [W:0]       mul_result;
  logic             mul_done;
  logic [W-1:0]     result;
  logic             busy;
  logic             done;

  logic mdl_done = 1'b0;
  logic inj_done = 1'b0;
  assign mul_done = mdl_done | inj_done;

  int  total = 0;
  int  bad = 0;
  int  rinv = 0;
  int  mul_lat = 5;
  int  mul_count = 0;
  op_t opq[$];
  int  resq[$];
  int  cntq[$];

  always #5 clk = ~clk;

  mont_exp_ctrl #(.W(W), .EXP_W(EXP_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_r(in_r), .in_e(in_e), .e_len(e_len), .in_m(in_m),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
    .mul_result(mul_result), .mul_done(mul_done),
    .result(result), .busy(busy), .done(done)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Montgomery product a*b*R^-1 mod M in plain arithmetic.
  function automatic int mm(input int a, input int b);
    return (a * b * rinv) % M;
  endfunction

  // Plain repeated multiplication: base^(e mod 2^len) mod M.
  function automatic int powmod(input int base, input int e, input int len);
    int ev;
    int r;
    ev = e & ((1 << len) - 1);
    r = 1;
    for (int i = 0; i < ev; i++) r = (r * base) % M;
    return r;
  endfunction

  // Behavioural multiplier: checks each request and answers after mul_lat cycles.
  initial begin : mult_model
    int pending;
    int cnt;
    int pa;
    int pb;
    op_t o;
    logic [W:0] r;
    pending = 0; cnt = 0; pa = 0; pb = 0;
    mul_result = '0;
    forever begin
      @(posedge clk);
      #2;
      mdl_done = 1'b0;
      if (!resetn) begin
        pending = 0;
      end else if (mul_start) begin
        chk("start_while_pending", pending, 0);
        chk("mul_m_value", int'(mul_m), M);
        chk("op_was_expected", int'(opq.size() > 0), 1);
        if (opq.size() > 0) begin
          o = opq.pop_front();
          chk("mul_a_value", int'(mul_a), o.a);
          chk("mul_b_value", int'(mul_b), o.b);
        end
        pending = 1;
        cnt = mul_lat;
        pa = int'(mul_a);
        pb = int'(mul_b);
        mul_count++;
      end else if (pending != 0) begin
        chk("mul_a_stable", int'(mul_a), pa);
        chk("mul_b_stable", int'(mul_b), pb);
        cnt--;
        if (cnt == 0) begin
          r[W-1:0] = W'(mm(pa, pb));
          r[W] = 1'($urandom_range(0, 1));
          mul_result = r;
          mdl_done = 1'b1;
          pending = 0;
        end
      end
    end
  end

  // Completion monitor: pops the expected result and multiply count on done.
  initial begin : done_monitor
    logic prev_done;
    int exp_res;
    int exp_cnt;
    prev_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (done) begin
        chk("done_single_cycle", int'(prev_done), 0);
        chk("busy_low_at_done", int'(busy), 0);
        chk("result_was_expected", int'(resq.size() > 0), 1);
        if (resq.size() > 0) begin
          exp_res = resq.pop_front();
          exp_cnt = cntq.pop_front();
          chk("result_value", int'(result), exp_res);
          chk("mul_count", mul_count, exp_cnt);
        end
      end
      prev_done = done;
    end
  end

  task automatic flush_queues();
    opq.delete();
    resq.delete();
    cntq.delete();
  endtask

  // Drive one request, queue its expectations and check the start-up latency.
  task automatic launch(input int xm, input int e, input int len);
    int acc;
    int pc;
    op_t o;
    in_x = W'(xm); in_r = W'(RM); in_e = EXP_W'(e); e_len = LEN_W'(len); in_m = W'(M);
    acc = RM;
    pc = 0;
    for (int i = len - 1; i >= 0; i--) begin
      o.a = acc; o.b = acc; opq.push_back(o);
      acc = mm(acc, acc);
      if (((e >> i) & 1) != 0) begin
        o.a = acc; o.b = xm; opq.push_back(o);
        acc = mm(acc, xm);
        pc++;
      end
    end
    o.a = acc; o.b = 1; opq.push_back(o);
    resq.push_back(powmod(mm(xm, 1), e, len));
    cntq.push_back(len + pc + 1);
    mul_count = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("no_early_mul_start", int'(mul_start), 0);
    @(posedge clk); #1;
    chk("no_early_mul_start2", int'(mul_start), 0);
    @(posedge clk); #1;
    chk("first_mul_latency", int'(mul_start), 1);
  endtask

  task automatic wait_done(input int budget);
    int got;
    got = 0;
    for (int i = 0; i < budget && got == 0; i++) begin
      @(posedge clk); #1;
      if (done) got = 1;
    end
    chk("done_within_budget", got, 1);
    if (got == 0) flush_queues();
    @(posedge clk); #1;
  endtask

  initial begin : main
    int xn;
    int xm;
    int seen;
    for (int i = 1; i < M; i++) if (((256 * i) % M) == 1) rinv = i;
    resetn = 1'b0; start = 1'b0;
    in_x = '0; in_r = '0; in_e = '0; e_len = '0; in_m = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_mul_start", int'(mul_start), 0);
    chk("rst_mul_a", int'(mul_a), 0);
    chk("rst_mul_b", int'(mul_b), 0);
    chk("rst_mul_m", int'(mul_m), 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // 5^13 mod 239 = 109
    launch(85, 13, 4);
    wait_done(400);
    chk("basic_109", int'(result), 109);

    // Empty exponent: only the conversion multiply
    launch(85, 13, 0);
    wait_done(400);
    chk("elen0_result", int'(result), 1);

    // All-zero exponent bits: squares and conversion only
    launch(85, 0, 3);
    wait_done(400);
    chk("zero_bits_result", int'(result), 1);

    // start while busy with different inputs must be ignored
    launch(85, 13, 4);
    repeat (4) @(posedge clk);
    #1;
    in_x = W'(5); in_e = EXP_W'(1); e_len = LEN_W'(1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(400);
    chk("busy_start_ignored", int'(result), 109);

    // Reset two cycles into MUL_W (second multiply of 5^13 is a MUL)
    launch(85, 13, 4);
    seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      @(posedge clk); #1;
      if (mul_start) seen = 1;
    end
    chk("second_mul_seen", seen, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b0;
    flush_queues();
    @(posedge clk); #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_mul_start", int'(mul_start), 0);
    resetn = 1'b1;
    @(posedge clk); #1;
    launch(85, 13, 4);
    wait_done(400);
    chk("after_rst_109", int'(result), 109);

    // Stray mul_done while idle
    inj_done = 1'b1;
    @(posedge clk); #1;
    inj_done = 1'b0;
    chk("inj_busy", int'(busy), 0);
    chk("inj_mul_start", int'(mul_start), 0);
    @(posedge clk); #1;
    chk("inj_busy2", int'(busy), 0);
    chk("inj_mul_start2", int'(mul_start), 0);
    @(posedge clk); #1;
    chk("inj_mul_start3", int'(mul_start), 0);

    // Slow multiplier: operands must hold for 20 cycles per multiply
    mul_lat = 20;
    launch(85, 13, 4);
    wait_done(1000);
    chk("slow_109", int'(result), 109);

    // Randomised runs
    for (int n = 0; n < 25; n++) begin
      mul_lat = $urandom_range(1, 8);
      xn = $urandom_range(0, M - 1);
      xm = (xn * 256) % M;
      launch(xm, int'($urandom_range(0, 255)), int'($urandom_range(0, 8)));
      wait_done(600);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("ops_left", opq.size(), 0);
    chk("results_left", resq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
